// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, sign helper.
// Helper operates on a fixed wide vector so any WIDTH up to 64 (2*WIDTH <= MD_MAX_W) can use it.
package multdiv_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam int MD_MAX_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Two's-complement negate when neg is set; callers zero-extend magnitudes into MD_MAX_W bits.
   function automatic logic [MD_MAX_W-1:0] cond_neg(input logic neg,
                                                    input logic [MD_MAX_W-1:0] v);
      return neg ? (~v + MD_MAX_W'(1)) : v;
   endfunction

endpackage

// File: rtl/multdiv_div_core.sv
// One restoring-divide step on unsigned magnitudes: shift dividend bit into remainder, trial-subtract.
// Purely combinational; the caller registers rem/quo once per cycle.
module multdiv_div_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < dvs always holds, so a set MSB of trial can only mean the subtraction went negative.
   assign shifted = {rem_i, quo_i[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_i};

   always_comb begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_o = trial[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed mul/div (radix-2, WIDTH cycles; div-by-zero 1 cycle), valid/ready both sides,
// result held in DONE until out_ready. Divider present only when MULTDIV_DIV_EN is defined.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_op_i,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic [TAG_W-1:0] in_tag_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_result_o,
   output logic             out_exception_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic             busy_o,
   output logic [TAG_W-1:0] busy_tag_o
);
   import multdiv_pkg::*;

   localparam int CNT_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d, neg_q, neg_d, zero_q, zero_d, exc_q, exc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic                handshake;
   logic                div_trivial;
   logic [MD_MAX_W-1:0] mag_a_ext, mag_b_ext, fin_ext;
   logic [WIDTH-1:0]    mag_a, mag_b;
   logic [WIDTH:0]      mul_sum;
   logic [WIDTH-1:0]    mul_hi, mul_lo, div_rem, div_quo, step_hi, step_lo;
   logic                fin_ok;
   logic                unused_ok;

   assign handshake = in_valid_i & in_ready_o & ~flush_i;

   assign mag_a_ext = cond_neg(in_a_i[WIDTH-1], MD_MAX_W'(in_a_i));
   assign mag_b_ext = cond_neg(in_b_i[WIDTH-1], MD_MAX_W'(in_b_i));
   assign mag_a     = mag_a_ext[WIDTH-1:0];
   assign mag_b     = mag_b_ext[WIDTH-1:0];
   assign unused_ok = ^{mag_a_ext[MD_MAX_W-1:WIDTH], mag_b_ext[MD_MAX_W-1:WIDTH]};

   // Shift-add: hi accumulates, lo holds the multiplier and collects product low bits.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
   multdiv_div_core #(.WIDTH(WIDTH)) u_div_core (
      .rem_i (hi_q),
      .quo_i (lo_q),
      .dvs_i (opnd_q),
      .rem_o (div_rem),
      .quo_o (div_quo)
   );
   assign div_trivial = (in_b_i == '0);
`else
   assign div_rem     = hi_q;
   assign div_quo     = lo_q;
   assign div_trivial = 1'b1;
`endif

   assign step_hi = (op_q == OP_DIV) ? div_rem : mul_hi;
   assign step_lo = (op_q == OP_DIV) ? div_quo : mul_lo;

   // Sign-corrected result in a wide vector: representable iff bits above WIDTH-2 all match.
   assign fin_ext = cond_neg(neg_q, (op_q == OP_DIV) ? MD_MAX_W'(step_lo)
                                                     : MD_MAX_W'({step_hi, step_lo}));
   assign fin_ok  = (&fin_ext[MD_MAX_W-1:WIDTH-1]) | ~(|fin_ext[MD_MAX_W-1:WIDTH-1]);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      zero_d   = zero_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      exc_d    = exc_q;
      tag_d    = tag_q;
      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d = RUN;
               op_d    = in_op_i;
               tag_d   = in_tag_i;
               neg_d   = in_a_i[WIDTH-1] ^ in_b_i[WIDTH-1];
               hi_d    = '0;
               if (in_op_i == OP_DIV) begin
                  // Trivial divides take a single RUN pass that forces result 0 / exception.
                  opnd_d = mag_b;
                  lo_d   = mag_a;
                  zero_d = div_trivial;
                  cnt_d  = div_trivial ? '0 : CNT_W'(WIDTH-1);
               end else begin
                  opnd_d = mag_a;
                  lo_d   = mag_b;
                  zero_d = 1'b0;
                  cnt_d  = CNT_W'(WIDTH-1);
               end
            end
         end
         RUN: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               cnt_d   = '0;
               if (zero_q) begin
                  result_d = '0;
                  exc_d    = 1'b1;
               end else begin
                  result_d = fin_ext[WIDTH-1:0];
                  exc_d    = ~fin_ok;
               end
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
         exc_q    <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
         exc_q    <= exc_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         tag_q    <= tag_d;
      end
   end

   assign in_ready_o      = (state_q == IDLE);
   assign out_valid_o     = (state_q == DONE);
   assign out_result_o    = result_q;
   assign out_exception_o = exc_q;
   assign out_tag_o       = tag_q;
   assign busy_o          = (state_q != IDLE);
   assign busy_tag_o      = busy_o ? tag_q : '0;

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Parametrised iterative signed multiply/divide unit for the pipelined processor's execute stage. It generalises the fixed 32-bit multdiv and product latch into one block with configurable operand width, a destination-register tag, and valid/ready handshakes on both sides. The unit reports busy state and tag to the stall logic, and supports a pipeline flush.

## Interface
- WIDTH, 32, operand/result width in bits (≥4, even)
- TAG_W, 5, destination-register tag width
- clock  in  1  master clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (state IDLE)
- in_op  in  1  0 = multiply, 1 = divide
- in_a, in_b  in  WIDTH  signed operands (A×B, A÷B)
- in_tag  in  TAG_W  destination register
- flush  in  1  synchronous kill of any in-flight op
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_result  out  WIDTH  signed result
- out_exception  out  1  overflow / divide-by-zero
- out_tag  out  TAG_W  tag of result
- busy  out  1  op in RUN or DONE
- busy_tag  out  TAG_W  tag of in-flight op (0 when idle)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: a handshake is in_valid & in_ready & ~flush. On a handshake, latch op/operands/tag, load counter = WIDTH−1, and go to RUN.
- Divide with in_b == 0: go straight to DONE with result 0, exception 1.
- RUN: one radix-2 step per cycle on operand magnitudes. Multiply is shift-add; divide is restoring. At counter == 0, apply sign correction and go to DONE.
- Multiply result: low WIDTH bits of the 2·WIDTH signed product.
  - exception = product not representable in signed WIDTH.
- Divide result: quotient truncated toward zero; remainder is discarded.
  - MIN ÷ −1: result MIN, exception 1.
- DONE: out_valid = 1, outputs held stable. On out_ready, go to IDLE.
- flush in any state: go to IDLE next edge and discard the result. flush wins over a simultaneous handshake or out_ready.
- in_ready = (state == IDLE). There is no accept in the same cycle as DONE retirement.

## Timing
- Reset (async assert): state IDLE, counter 0.
  - out_valid, out_result, out_exception, out_tag, busy, busy_tag all 0.
  - in_ready 1.
- Latency: handshake at edge N gives out_valid high after edge N+WIDTH.
- Divide-by-zero latency: out_valid high after edge N+1.
- Backpressure: out_valid stays high and outputs are unchanged until the edge where out_ready = 1. out_valid falls after that edge.
- Throughput: at most one op per WIDTH+1 cycles (+ stall cycles).
- busy rises the cycle after the handshake and falls the cycle after retirement or flush.
- Reset deasserted mid-operation: the unit restarts in IDLE. Partial state is never exposed.

## Configuration
- MULTDIV_DIV_EN defined: divider datapath present, behaviour as above.
- MULTDIV_DIV_EN undefined: divider logic removed.
  - op = 1 is accepted and goes IDLE→DONE in one cycle with result 0, exception 1.
  - Multiply is unchanged.

## Structure
- Package multdiv_pkg holds:
  - op encoding constants (OP_MUL = 0, OP_DIV = 1)
  - state enum (IDLE/RUN/DONE)
  - helper for signed magnitude/negate
- One sub-module is natural: multdiv_div_core, the restoring-divide step datapath. It is instantiated only under MULTDIV_DIV_EN.
- FSM, counter, multiply datapath and handshakes stay in multdiv_unit.

## Test plan
- WIDTH=32, mul 6×−7, tag 9, out_ready=1 → after 32 cycles: result −42, exception 0, tag 9; in_ready high the next cycle.
- mul 0x00010000×0x00010000 → result 0x00000000, exception 1.
- div −7÷2 → −3, exception 0; div 0x80000000÷−1 → 0x80000000, exception 1; div 5÷0 → 0, exception 1, out_valid one cycle after handshake.
- Hold out_ready=0 for 10 cycles after done → out_valid and outputs stable; retire on out_ready=1; busy falls the next cycle.
- flush asserted at cycle 12 of a multiply, with in_valid also high → IDLE, no output, no accept; a new op on the next cycle completes correctly.
- Reset pulsed low mid-divide → all outputs 0 immediately, in_ready 1. Repeat with MULTDIV_DIV_EN undefined: div 10÷2 → 0, exception 1 in one cycle.
